serial_add_ctrl: RTL

//  Bit-serial adder sequencer that sits in front of the 1-bit full adder (a, b, ci -> s, co).
//  - Accepts two WIDTH-bit operands and a carry-in.
//  - Drives the full adder one bit per clock, LSB first.
//  - Captures the s/co results and presents the full WIDTH-bit sum plus carry-out with a done pulse.

---
 rtl/serial_add_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder LSB first and collects the sum.
// Optional macro SERIAL_ADD_OVF_EN adds the ovf output (two's-complement overflow).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_sh_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last_bit;

    // Handshake: start is a request that is taken only when busy==0 (IDLE or DONE);
    // while busy==1 it is ignored and operands are not re-sampled. done marks sum/cout valid.
    assign accept   = (state != S_RUN) && start;
    assign last_bit = (state == S_RUN) && (cnt == LAST);

    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_sh_next = fa_s;
        end else begin : g_wn
            assign sum_sh_next = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_RUN);
        done      = (state == S_DONE);
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_ci     = 1'b0;
        dbg_state = state;
        if (state == S_RUN) begin
            fa_a  = a_sh[0];
            fa_b  = b_sh[0];
            fa_ci = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_sh_next;
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                sum  <= sum_sh_next;
                cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                // carry still holds the carry into the MSB on the last bit
                ovf  <= carry ^ fa_co;
`endif
            end
        end
    end

endmodule
